// File: rtl/sprite_renderer.sv
// 2-bit-per-pixel sprite renderer: window test against per-frame shadow position,
// sprite ROM addressing, and palette lookup with a valid/opaque flag for layering.
module sprite_renderer #(
    parameter int SPR_W     = 78,
    parameter int SPR_H     = 53,
    parameter int ADDR_W    = 13,
    parameter int ROM_LAT   = 1,
    parameter int IDLE_ADDR = 0,
    parameter int HC_W      = 11,
    parameter int VC_W      = 10
) (
    input  logic              vclk,
    input  logic              rst,
    input  logic [HC_W-1:0]   hcount,
    input  logic [VC_W-1:0]   vcount,
    input  logic [HC_W-1:0]   x_pos,
    input  logic [VC_W-1:0]   y_pos,
    input  logic              enable,
    input  logic [7:0]        color_a,
    input  logic [7:0]        color_b,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [1:0]        rom_data,
    output logic [7:0]        pixel,
    output logic              pixel_valid
);

    localparam logic [HC_W:0]     W_EXT    = (HC_W+1)'(SPR_W);
    localparam logic [VC_W:0]     H_EXT    = (VC_W+1)'(SPR_H);
    localparam logic [ADDR_W:0]   W_ADDR   = (ADDR_W+1)'(SPR_W);
    localparam logic [ADDR_W:0]   ROW_MAX  = (ADDR_W+1)'(SPR_W * SPR_H);
    localparam logic [ADDR_W-1:0] IDLE_A   = ADDR_W'(IDLE_ADDR);

    // Per-frame shadow copies of the runtime controls
    logic [HC_W-1:0]   x_reg;
    logic [VC_W-1:0]   y_reg;
    logic              en_reg;
    logic [7:0]        ca_reg;
    logic [7:0]        cb_reg;
    logic [ADDR_W:0]   row_base_reg;
    logic [ADDR_W-1:0] rom_addr_reg;
    logic [7:0]        pixel_reg;
    logic              valid_reg;
    logic [ROM_LAT:0]  hit_pipe_reg;
    logic [ROM_LAT:0]  hit_next;

    logic              frame_start;
    logic [HC_W:0]     h_ext;
    logic [HC_W:0]     x_end;
    logic [VC_W:0]     v_ext;
    logic [VC_W:0]     y_end;
    logic              hit;
    logic              last_col;
    logic [HC_W-1:0]   col_off;
    logic [ADDR_W-1:0] addr_next;

    // Extended-width sums keep a window near the right/bottom edge from wrapping to 0
    assign frame_start = (hcount == '0) && (vcount == '0);
    assign h_ext       = {1'b0, hcount};
    assign v_ext       = {1'b0, vcount};
    assign x_end       = {1'b0, x_reg} + W_EXT;
    assign y_end       = {1'b0, y_reg} + H_EXT;
    assign hit         = en_reg
                         && (h_ext >= {1'b0, x_reg}) && (h_ext < x_end)
                         && (v_ext >= {1'b0, y_reg}) && (v_ext < y_end);
    assign last_col    = (h_ext == (x_end - (HC_W+1)'(1)));
    assign col_off     = hcount - x_reg;
    assign addr_next   = ADDR_W'(row_base_reg + (ADDR_W+1)'(col_off));

    always_ff @(posedge vclk or posedge rst) begin
        if (rst) begin
            x_reg        <= '0;
            y_reg        <= '0;
            en_reg       <= 1'b0;
            ca_reg       <= '0;
            cb_reg       <= '0;
            row_base_reg <= '0;
        end else if (frame_start) begin
            x_reg        <= x_pos;
            y_reg        <= y_pos;
            en_reg       <= enable;
            ca_reg       <= color_a;
            cb_reg       <= color_b;
            row_base_reg <= '0;
        end else if (hit && last_col && (row_base_reg != ROW_MAX)) begin
            row_base_reg <= row_base_reg + W_ADDR;
        end
    end

    always_ff @(posedge vclk or posedge rst) begin
        if (rst) begin
            rom_addr_reg <= IDLE_A;
        end else begin
            rom_addr_reg <= hit ? addr_next : IDLE_A;
        end
    end

    // Hit flag delayed 1+ROM_LAT cycles so it lines up with the returned ROM code
    assign hit_next[0] = hit;
    generate
        for (genvar gi = 1; gi <= ROM_LAT; gi++) begin : g_hit_dly
            assign hit_next[gi] = hit_pipe_reg[gi-1];
        end
    endgenerate

    always_ff @(posedge vclk or posedge rst) begin
        if (rst) begin
            hit_pipe_reg <= '0;
        end else begin
            hit_pipe_reg <= hit_next;
        end
    end

    always_ff @(posedge vclk or posedge rst) begin
        if (rst) begin
            pixel_reg <= 8'h00;
            valid_reg <= 1'b0;
        end else if (!hit_pipe_reg[ROM_LAT]) begin
            pixel_reg <= 8'h00;
            valid_reg <= 1'b0;
        end else begin
            case (rom_data)
                2'b01:   begin pixel_reg <= ca_reg; valid_reg <= 1'b1; end
                2'b10:   begin pixel_reg <= cb_reg; valid_reg <= 1'b1; end
                2'b11:   begin pixel_reg <= 8'hFF;  valid_reg <= 1'b1; end
                default: begin pixel_reg <= 8'h00;  valid_reg <= 1'b0; end
            endcase
        end
    end

    assign rom_addr    = rom_addr_reg;
    assign pixel       = pixel_reg;
    assign pixel_valid = valid_reg;

endmodule

// File: tb/tb_sprite_renderer.sv
// Randomised frame scans on two renderer configurations, checked cycle by cycle
// against a window/row-count reference model of the sprite raster.
module tb_sprite_renderer;

    localparam int W0 = 78, H0 = 53, L0 = 1;
    localparam int W1 = 1,  H1 = 4,  L1 = 3;

    logic        vclk = 1'b0;
    logic        rst;
    logic [10:0] hcount, x_pos;
    logic [9:0]  vcount, y_pos;
    logic        enable;
    logic [7:0]  color_a, color_b;
    logic [12:0] rom_addr0, rom_addr1;
    logic [1:0]  rom_data0, rom_data1;
    logic [7:0]  pixel0, pixel1;
    logic        pv0, pv1;
    logic [1:0]  rp0 [0:3];
    logic [1:0]  rp1 [0:3];

    always #5 vclk = ~vclk;

    sprite_renderer #(.SPR_W(W0), .SPR_H(H0), .ADDR_W(13), .ROM_LAT(L0), .IDLE_ADDR(0),
                      .HC_W(11), .VC_W(10)) dut0 (
        .vclk(vclk), .rst(rst), .hcount(hcount), .vcount(vcount), .x_pos(x_pos),
        .y_pos(y_pos), .enable(enable), .color_a(color_a), .color_b(color_b),
        .rom_addr(rom_addr0), .rom_data(rom_data0), .pixel(pixel0), .pixel_valid(pv0));

    sprite_renderer #(.SPR_W(W1), .SPR_H(H1), .ADDR_W(13), .ROM_LAT(L1), .IDLE_ADDR(0),
                      .HC_W(11), .VC_W(10)) dut1 (
        .vclk(vclk), .rst(rst), .hcount(hcount), .vcount(vcount), .x_pos(x_pos),
        .y_pos(y_pos), .enable(enable), .color_a(color_a), .color_b(color_b),
        .rom_addr(rom_addr1), .rom_data(rom_data1), .pixel(pixel1), .pixel_valid(pv1));

    // Sprite ROMs: content is addr[1:0], read latency per instance
    always @(posedge vclk) begin
        rp0[0] <= rom_addr0[1:0];
        rp1[0] <= rom_addr1[1:0];
        for (int k = 1; k < 4; k++) begin
            rp0[k] <= rp0[k-1];
            rp1[k] <= rp1[k-1];
        end
    end
    assign rom_data0 = rp0[L0-1];
    assign rom_data1 = rp1[L1-1];

    typedef struct packed {
        logic [12:0] addr;
        logic [7:0]  pix;
        logic        vld;
    } res_t;

    int   errors = 0;
    int   checks = 0;
    int   cycles = 0;
    int   cur_h, cur_v;
    int   sx, sy;
    bit   sen;
    logic [7:0] sca, scb;
    int   rows [2];
    int   mw [2];
    int   mh [2];
    res_t hist [2][8];
    bit   probe;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s h=%0d v=%0d: got %0h expected %0h", tag, cur_h, cur_v, obs, exp);
        end
    endtask

    task automatic model_clear();
        sx = 0; sy = 0; sen = 1'b0; sca = 8'h00; scb = 8'h00;
        rows[0] = 0; rows[1] = 0;
        for (int i = 0; i < 2; i++)
            for (int k = 0; k < 8; k++) hist[i][k] = '0;
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_addr0"}, 32'(rom_addr0), 32'd0);
        check({tag, "_pix0"},  32'(pixel0),    32'd0);
        check({tag, "_vld0"},  32'(pv0),       32'd0);
        check({tag, "_addr1"}, 32'(rom_addr1), 32'd0);
        check({tag, "_pix1"},  32'(pixel1),    32'd0);
        check({tag, "_vld1"},  32'(pv1),       32'd0);
    endtask

    // One pixel clock: present (h,v), predict, clock, compare
    task automatic step(input int h, input int v);
        res_t cur [2];
        bit   hit [2];
        int   a;
        cur_h = h; cur_v = v;
        hcount = 11'(h);
        vcount = 10'(v);
        for (int i = 0; i < 2; i++) begin
            hit[i] = sen && (h >= sx) && (h < sx + mw[i]) && (v >= sy) && (v < sy + mh[i]);
            cur[i] = '0;
            if (hit[i]) begin
                a = (rows[i] * mw[i] + h - sx) % 8192;
                cur[i].addr = 13'(a);
                case (a % 4)
                    1:       begin cur[i].pix = sca;   cur[i].vld = 1'b1; end
                    2:       begin cur[i].pix = scb;   cur[i].vld = 1'b1; end
                    3:       begin cur[i].pix = 8'hFF; cur[i].vld = 1'b1; end
                    default: begin cur[i].pix = 8'h00; cur[i].vld = 1'b0; end
                endcase
            end
        end
        @(posedge vclk);
        if (h == 0 && v == 0) begin
            sx = int'(x_pos); sy = int'(y_pos); sen = enable;
            sca = color_a; scb = color_b;
            rows[0] = 0; rows[1] = 0;
        end else begin
            for (int i = 0; i < 2; i++)
                if (hit[i] && h == sx + mw[i] - 1) rows[i]++;
        end
        for (int i = 0; i < 2; i++) begin
            for (int k = 7; k > 0; k--) hist[i][k] = hist[i][k-1];
            hist[i][0] = cur[i];
        end
        #1;
        check("addr0", 32'(rom_addr0), 32'(hist[0][0].addr));
        check("pix0",  32'(pixel0),    32'(hist[0][L0+1].pix));
        check("vld0",  32'(pv0),       32'(hist[0][L0+1].vld));
        check("addr1", 32'(rom_addr1), 32'(hist[1][0].addr));
        check("pix1",  32'(pixel1),    32'(hist[1][L1+1].pix));
        check("vld1",  32'(pv1),       32'(hist[1][L1+1].vld));
        if (probe && h == 285 && v == 355) check("addr_285_355", 32'(rom_addr0), 32'd4133);
        cycles++;
    endtask

    task automatic mid_reset();
        @(negedge vclk);
        rst = 1'b1;
        #1;
        check_idle("midrst");
        model_clear();
        @(posedge vclk);
        #1;
        rst = 1'b0;
    endtask

    task automatic randomize_inputs();
        x_pos   = 11'($urandom);
        y_pos   = 10'($urandom);
        enable  = 1'($urandom);
        color_a = 8'($urandom);
        color_b = 8'($urandom);
    endtask

    // Frame: line 0 cols 0..7 (frame start first), then lines ylo..yhi with cols 0..7 and xlo..xhi
    task automatic run_frame(input int fno, input int xlo, input int xhi, input int ylo,
                             input int yhi, input int rst_line, input int new_x, input bit junk);
        int e0 = errors;
        for (int h = 0; h < 8; h++) begin
            step(h, 0);
            if (h == 0 && junk) randomize_inputs();
        end
        for (int v = ylo; v <= yhi; v++) begin
            for (int h = 0; h < 8; h++) step(h, v);
            for (int h = (xlo < 8 ? 8 : xlo); h <= xhi; h++) begin
                step(h, v);
                if (v == rst_line && h == xlo + 40) mid_reset();
                if (v == ylo + 10 && h == xlo && new_x >= 0) begin
                    x_pos = 11'(new_x); color_a = 8'($urandom); color_b = 8'($urandom);
                end
                if (junk && h == xlo + 5) randomize_inputs();
            end
        end
        $display("frame %0d: shadow x=%0d y=%0d en=%0d cols %0d..%0d lines %0d..%0d cycles=%0d new_errors=%0d",
                 fno, sx, sy, sen, xlo, xhi, ylo, yhi, cycles, errors - e0);
    endtask

    task automatic set_cfg(input int x, input int y, input bit en, input logic [7:0] ca,
                           input logic [7:0] cb);
        x_pos = 11'(x); y_pos = 10'(y); enable = en; color_a = ca; color_b = cb;
    endtask

    initial begin
        int x, y;
        mw[0] = W0; mw[1] = W1; mh[0] = H0; mh[1] = H1;
        probe  = 1'b0;
        rst    = 1'b1;
        hcount = '0; vcount = '0;
        set_cfg(208, 303, 1'b1, 8'h2B, 8'h1C);
        model_clear();
        repeat (3) @(posedge vclk);
        #1;
        check_idle("reset");
        rst = 1'b0;

        // Nominal window; x_pos moved to 400 mid-frame must not take effect yet
        probe = 1'b1;
        run_frame(1, 205, 290, 300, 358, -1, 400, 1'b0);
        probe = 1'b0;
        set_cfg(400, 303, 1'b1, 8'h2B, 8'h1C);
        run_frame(2, 397, 482, 300, 358, -1, -1, 1'b0);
        // Reset inside the window at line 320 with enable held high
        set_cfg(208, 303, 1'b1, 8'h5A, 8'hA5);
        run_frame(3, 205, 290, 300, 358, 320, -1, 1'b0);
        run_frame(4, 205, 290, 300, 358, -1, -1, 1'b0);
        // Off-screen positions and the wide-hcount edge cases
        set_cfg(2000, 303, 1'b1, 8'h11, 8'h22);
        run_frame(5, 1270, 1279, 300, 310, -1, -1, 1'b0);
        set_cfg(208, 1000, 1'b1, 8'h11, 8'h22);
        run_frame(6, 205, 290, 1, 20, -1, -1, 1'b0);
        set_cfg(1023, 100, 1'b1, 8'h33, 8'h44);
        run_frame(7, 1020, 1103, 98, 155, -1, -1, 1'b0);
        set_cfg(2040, 50, 1'b1, 8'h55, 8'h66);
        run_frame(8, 2035, 2047, 48, 105, -1, -1, 1'b0);
        set_cfg(208, 303, 1'b0, 8'h77, 8'h88);
        run_frame(9, 205, 290, 300, 310, -1, -1, 1'b0);

        // Random placements with inputs scrambled between frame starts
        for (int f = 10; f < 14; f++) begin
            x = $urandom_range(8, 1100);
            y = $urandom_range(4, 400);
            set_cfg(x, y, ($urandom_range(0, 3) != 0), 8'($urandom), 8'($urandom));
            run_frame(f, x - 3, x + W0 + 3, y - 2, y + H0 + 2, -1, -1, 1'b1);
            set_cfg(x, y, 1'b1, 8'($urandom), 8'($urandom));
        end
        run_frame(14, 0, 7, 1, 2, -1, -1, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
